// File: rtl/core_pipe_pkg.sv
// Shared definitions for the MIPS32 pipeline stage registers.
//   PIPE_OCC_W      width of the occupancy count (0..2 held beats)
//   pipe_entry_t    {data, ctrl, sticky} beat at the default core widths
//   CTRL_*          bit positions inside the control field, so every stage
//                   instantiation agrees on where RegWrite, Issued, ... live
//   occ_count()     number of held beats from the entry valid bits
package core_pipe_pkg;

  localparam int PIPE_OCC_W    = 2;

  localparam int PIPE_DATA_W   = 32;
  localparam int PIPE_CTRL_W   = 8;
  localparam int PIPE_STICKY_W = 32;

  typedef struct packed {
    logic [PIPE_DATA_W-1:0]   data;
    logic [PIPE_CTRL_W-1:0]   ctrl;
    logic [PIPE_STICKY_W-1:0] sticky;
  } pipe_entry_t;

  localparam int CTRL_REGWRITE  = 0;
  localparam int CTRL_MEMTOREG  = 1;
  localparam int CTRL_MEMWRITE  = 2;
  localparam int CTRL_MEMREAD   = 3;
  localparam int CTRL_BRANCH    = 4;
  localparam int CTRL_JUMP      = 5;
  localparam int CTRL_ISSUED    = 6;
  localparam int CTRL_EXCEPTION = 7;

  function automatic logic [PIPE_OCC_W-1:0] occ_count(input logic m_vld,
                                                      input logic s_vld);
    return {1'b0, m_vld} + {1'b0, s_vld};
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for pipeline performance monitoring.
//   clock, reset  core clock, synchronous active-high reset (zeroes count)
//   inc           count one event this cycle
//   clr           synchronous clear, wins over inc
//   count         current value, sticks at all-ones
module pipe_sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline register between two MIPS32 core stages.
// Carries a payload, a control field (cleared by reset/flush and masked
// while no beat is held) and a sticky field (RestartPC-style, optionally
// held) over a valid/ready handshake. With SKID=1 a second entry makes
// in_ready a pure register output so ready does not ripple back through
// stages combinationally.
//   clock, reset        core clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake
//   in_data/ctrl/sticky upstream beat
//   sticky_hold         keep the old out_sticky on this load of the output entry
//   flush               drop all held beats and the incoming beat
//   out_valid/out_ready downstream handshake
//   out_data/ctrl/sticky output beat (out_ctrl is 0 when out_valid is 0)
//   occupancy           held beats, 0..1+SKID
//   stall_count         saturating count of out_valid & ~out_ready cycles
//   clear_count         synchronous clear of stall_count
module pipe_stage_reg
  import core_pipe_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int CTRL_WIDTH   = 8,
  parameter int STICKY_WIDTH = 32,
  parameter int SKID         = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [CTRL_WIDTH-1:0]   in_ctrl,
  input  logic [STICKY_WIDTH-1:0] in_sticky,
  input  logic                    sticky_hold,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [CTRL_WIDTH-1:0]   out_ctrl,
  output logic [STICKY_WIDTH-1:0] out_sticky,
  output logic [PIPE_OCC_W-1:0]   occupancy,
  output logic [CNT_WIDTH-1:0]    stall_count,
  input  logic                    clear_count
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]   data;
    logic [CTRL_WIDTH-1:0]   ctrl;
    logic [STICKY_WIDTH-1:0] sticky;
  } entry_t;

  entry_t                  in_beat;
  entry_t                  load_src;
  logic                    load_m;
  logic                    m_vld_nxt;
  logic                    xfer_in;
  logic                    xfer_out;
  logic                    s_vld_p0;

  logic                    vld_p0;
  logic [DATA_WIDTH-1:0]   data_p0;
  logic [CTRL_WIDTH-1:0]   ctrl_p0;
  logic [STICKY_WIDTH-1:0] sticky_p0;

  assign in_beat  = '{data: in_data, ctrl: in_ctrl, sticky: in_sticky};
  assign xfer_in  = in_valid & in_ready & ~flush;
  assign xfer_out = vld_p0 & out_ready;

  generate
    if (SKID == 0) begin : g_noskid
      // Single entry: a slot frees up in the same cycle the output drains.
      assign in_ready = ~vld_p0 | out_ready;
      assign s_vld_p0 = 1'b0;
      assign load_m   = xfer_in;
      assign load_src = in_beat;

      always_comb begin
        m_vld_nxt = vld_p0;
        if (xfer_in) begin
          m_vld_nxt = 1'b1;
        end else if (xfer_out) begin
          m_vld_nxt = 1'b0;
        end
      end
    end else begin : g_skid
      entry_t s_p0;
      logic   s_vld_r;
      logic   s_load;
      logic   s_vld_nxt;
      logic   drain;

      // Only the skid entry's valid gates acceptance, so in_ready is a flop.
      assign in_ready = ~s_vld_r;
      assign s_vld_p0 = s_vld_r;
      assign drain    = ~vld_p0 | out_ready;

      always_comb begin
        load_m    = 1'b0;
        load_src  = in_beat;
        m_vld_nxt = vld_p0;
        s_load    = 1'b0;
        s_vld_nxt = s_vld_r;
        if (drain) begin
          if (s_vld_r) begin
            // Older beat in S moves forward first; the new beat refills S.
            load_m    = 1'b1;
            load_src  = s_p0;
            m_vld_nxt = 1'b1;
            s_load    = xfer_in;
            s_vld_nxt = xfer_in;
          end else begin
            load_m    = xfer_in;
            m_vld_nxt = xfer_in;
          end
        end else if (xfer_in) begin
          s_load    = 1'b1;
          s_vld_nxt = 1'b1;
        end
      end

      // ---- skid entry ----
      always_ff @(posedge clock) begin
        if (reset || flush) begin
          s_vld_r <= 1'b0;
        end else begin
          s_vld_r <= s_vld_nxt;
        end
      end

      always_ff @(posedge clock) begin
        if (s_load) begin
          s_p0 <= in_beat;
        end
      end
    end
  endgenerate

  // ---- output entry ----
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p0    <= 1'b0;
      data_p0   <= '0;
      ctrl_p0   <= '0;
      sticky_p0 <= '0;
    end else if (flush) begin
      vld_p0  <= 1'b0;
      ctrl_p0 <= '0;
    end else begin
      vld_p0 <= m_vld_nxt;
      if (load_m) begin
        data_p0 <= load_src.data;
        ctrl_p0 <= load_src.ctrl;
        if (!sticky_hold) begin
          sticky_p0 <= load_src.sticky;
        end
      end
    end
  end

  assign out_valid  = vld_p0;
  assign out_data   = data_p0;
  assign out_ctrl   = vld_p0 ? ctrl_p0 : '0;
  assign out_sticky = sticky_p0;
  assign occupancy  = occ_count(vld_p0, s_vld_p0);

  pipe_sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_stall_cnt (
    .clock(clock),
    .reset(reset),
    .inc  (vld_p0 & ~out_ready),
    .clr  (clear_count),
    .count(stall_count)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  // SKID=1, 4-bit counter instance
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_data = '0, in_sticky = '0;
  logic [7:0]  in_ctrl = '0;
  logic        sticky_hold = 1'b0, flush = 1'b0, clear_count = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_data, out_sticky;
  logic [7:0]  out_ctrl;
  logic [1:0]  occupancy;
  logic [3:0]  stall_count;

  // SKID=0 instance
  logic        z_in_valid = 1'b0, z_in_ready;
  logic [31:0] z_in_data = '0, z_in_sticky = '0;
  logic [7:0]  z_in_ctrl = '0;
  logic        z_out_valid, z_out_ready = 1'b0;
  logic [31:0] z_out_data, z_out_sticky;
  logic [7:0]  z_out_ctrl;
  logic [1:0]  z_occupancy;
  logic [15:0] z_stall_count;

  always #5 clock = ~clock;

  pipe_stage_reg #(.DATA_WIDTH(32), .CTRL_WIDTH(8), .STICKY_WIDTH(32),
                   .SKID(1), .CNT_WIDTH(4)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_ctrl(in_ctrl), .in_sticky(in_sticky), .sticky_hold(sticky_hold),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_sticky(out_sticky),
    .occupancy(occupancy), .stall_count(stall_count), .clear_count(clear_count)
  );

  pipe_stage_reg #(.DATA_WIDTH(32), .CTRL_WIDTH(8), .STICKY_WIDTH(32),
                   .SKID(0), .CNT_WIDTH(16)) dut0 (
    .clock(clock), .reset(reset),
    .in_valid(z_in_valid), .in_ready(z_in_ready), .in_data(z_in_data),
    .in_ctrl(z_in_ctrl), .in_sticky(z_in_sticky), .sticky_hold(1'b0),
    .flush(1'b0), .out_valid(z_out_valid), .out_ready(z_out_ready),
    .out_data(z_out_data), .out_ctrl(z_out_ctrl), .out_sticky(z_out_sticky),
    .occupancy(z_occupancy), .stall_count(z_stall_count), .clear_count(1'b0)
  );

  typedef struct {
    logic [31:0] d;
    logic [7:0]  c;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops an expected beat on every output handshake.
  always @(negedge clock) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: got beat 0x%0h expected none", out_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_data", out_data, e.d);
          chk("sb_ctrl", {24'h0, out_ctrl}, {24'h0, e.c});
        end
      end else if (!out_valid) begin
        chk("ctrl_masked", {24'h0, out_ctrl}, 32'h0);
      end
    end
  end

  // Present a beat and wait (bounded) until it is accepted.
  task automatic send(input logic [31:0] d, input logic [7:0] c,
                      input logic [31:0] st, input logic hold, input bit push);
    bit ok = 1'b0;
    @(posedge clock); #1;
    in_valid    = 1'b1;
    in_data     = d;
    in_ctrl     = c;
    in_sticky   = st;
    sticky_hold = hold;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: beat 0x%0h not accepted, required accept", d);
    end else if (push) begin
      sb.push_back('{d: d, c: c});
    end
  endtask

  task automatic idle();
    @(posedge clock); #1;
    in_valid    = 1'b0;
    sticky_hold = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_ctrl", {24'h0, out_ctrl}, 32'h0);
    chk("rst_out_sticky", out_sticky, 32'h0);
    chk("rst_occupancy", {30'h0, occupancy}, 32'h0);
    chk("rst_stall", {28'h0, stall_count}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);

    // Stream 1..8 at full throughput
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(i, 8'(i) ^ 8'h41, 32'h0, 1'b0, 1'b1);
      if (i >= 2) begin
        chk("stream_no_bubble", {31'h0, out_valid}, 32'h1);
        chk("stream_latency", out_data, i - 1);
        chk("stream_occ_le1", {31'h0, (occupancy <= 2'd1)}, 32'h1);
      end
    end
    idle();
    repeat (2) @(posedge clock);
    #1 chk("stream_stall", {28'h0, stall_count}, 32'h0);

    // Backpressure with skid entry
    out_ready = 1'b0;
    send(32'hA, 8'h0A, 32'h0, 1'b0, 1'b1);
    send(32'hB, 8'h0B, 32'h0, 1'b0, 1'b1);
    @(posedge clock); #1;
    in_data = 32'hC; in_ctrl = 8'h0C; in_valid = 1'b1;
    @(negedge clock);
    chk("bp_in_ready_low", {31'h0, in_ready}, 32'h0);
    chk("bp_occupancy2", {30'h0, occupancy}, 32'h2);
    repeat (3) @(posedge clock);
    #1 out_ready = 1'b1;
    @(negedge clock);
    chk("bp_stall_count", {28'h0, stall_count}, 32'h4);
    chk("bp_c_not_taken", {31'h0, in_ready}, 32'h0);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (k > 0) @(negedge clock);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("bp_c_accepted", {31'h0, ok}, 32'h1);
    if (ok) sb.push_back('{d: 32'hC, c: 8'h0C});
    idle();
    repeat (3) @(posedge clock);

    // Sticky hold
    send(32'h11, 8'h01, 32'h100, 1'b0, 1'b1);
    idle();
    chk("sticky_load", out_sticky, 32'h100);
    send(32'h22, 8'h02, 32'h200, 1'b1, 1'b1);
    idle();
    chk("sticky_held", out_sticky, 32'h100);
    chk("sticky_data_adv", out_data, 32'h22);
    send(32'h33, 8'h03, 32'h300, 1'b0, 1'b1);
    idle();
    chk("sticky_reload", out_sticky, 32'h300);
    repeat (2) @(posedge clock);
    #1 chk("sticky_no_load", out_sticky, 32'h300);

    // Flush with two held beats plus an incoming one
    out_ready = 1'b0;
    send(32'hD1, 8'h81, 32'h0, 1'b0, 1'b0);
    send(32'hD2, 8'h82, 32'h0, 1'b0, 1'b0);
    @(posedge clock); #1;
    in_data = 32'hD3; in_ctrl = 8'h83; in_valid = 1'b1; flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", {31'h0, out_valid}, 32'h0);
    chk("flush_out_ctrl", {24'h0, out_ctrl}, 32'h0);
    chk("flush_occupancy", {30'h0, occupancy}, 32'h0);
    chk("flush_keeps_data", out_data, 32'hD1);
    chk("flush_in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clock); #1;
    in_data = 32'hD4; in_ctrl = 8'h84; in_valid = 1'b1; flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush2_out_valid", {31'h0, out_valid}, 32'h0);
    chk("flush2_occupancy", {30'h0, occupancy}, 32'h0);
    out_ready = 1'b1;
    send(32'hD5, 8'h85, 32'h0, 1'b0, 1'b1);
    idle();
    repeat (2) @(posedge clock);

    // Counter saturation and clear
    out_ready = 1'b0;
    send(32'hE1, 8'h91, 32'h0, 1'b0, 1'b1);
    idle();
    clear_count = 1'b1;
    @(posedge clock); #1 clear_count = 1'b0;
    chk("cnt_cleared", {28'h0, stall_count}, 32'h0);
    repeat (20) @(posedge clock);
    #1 chk("cnt_saturated", {28'h0, stall_count}, 32'hF);
    clear_count = 1'b1;
    @(posedge clock); #1 clear_count = 1'b0;
    chk("cnt_clear_in_stall", {28'h0, stall_count}, 32'h0);
    @(posedge clock);
    #1 chk("cnt_resume1", {28'h0, stall_count}, 32'h1);
    @(posedge clock);
    #1 chk("cnt_resume2", {28'h0, stall_count}, 32'h2);
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;

    // Reset mid-transfer
    out_ready = 1'b0;
    send(32'hF1, 8'hA1, 32'h55, 1'b0, 1'b0);
    send(32'hF2, 8'hA2, 32'h66, 1'b0, 1'b0);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0; in_valid = 1'b0;
    chk("rst2_occupancy", {30'h0, occupancy}, 32'h0);
    chk("rst2_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst2_out_data", out_data, 32'h0);
    chk("rst2_out_sticky", out_sticky, 32'h0);
    chk("rst2_in_ready", {31'h0, in_ready}, 32'h1);

    // SKID=0 build: combinational ready and pass-through
    z_in_valid = 1'b1; z_in_data = 32'h55; z_in_ctrl = 8'h15; z_out_ready = 1'b0;
    @(posedge clock); #1;
    chk("z_full_valid", {31'h0, z_out_valid}, 32'h1);
    chk("z_in_ready_low", {31'h0, z_in_ready}, 32'h0);
    z_out_ready = 1'b1;
    #1 chk("z_in_ready_comb", {31'h0, z_in_ready}, 32'h1);
    z_in_data = 32'h66; z_in_ctrl = 8'h16;
    @(posedge clock); #1;
    chk("z_passthru_data", z_out_data, 32'h66);
    chk("z_passthru_ctrl", {24'h0, z_out_ctrl}, 32'h16);
    chk("z_occupancy1", {30'h0, z_occupancy}, 32'h1);
    z_in_valid = 1'b0;
    @(posedge clock); #1;
    chk("z_drained", {31'h0, z_out_valid}, 32'h0);
    chk("z_ctrl_masked", {24'h0, z_out_ctrl}, 32'h0);
    chk("z_stall", {16'h0, z_stall_count}, 32'h0);

    repeat (2) @(posedge clock);
    #1 chk("sb_empty", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
